// File: rtl/intr_ctrl_n_if.sv
// CU-side request channel of the interrupt controller: a four-phase req/ack
// handshake plus the exception code and handler entry address that travel
// with the request.
interface intr_ctrl_n_if #(
  parameter int CODE_W = 4
) ();
  logic              cu_req;
  logic              cu_ack;
  logic [CODE_W-1:0] excep_code;
  logic [0:31]       intr_entry_addr;

  // Controller side: raises the request and presents code/address.
  modport master (
    output cu_req,
    output excep_code,
    output intr_entry_addr,
    input  cu_ack
  );

  // Control-unit side: observes the request and acknowledges it.
  modport slave (
    input  cu_req,
    input  excep_code,
    input  intr_entry_addr,
    output cu_ack
  );
endinterface

// File: rtl/intr_ctrl_n.sv
// Parametrised interrupt controller: N_SRC sticky pending latches, an
// enable mask, per-source non-maskable attribute, fixed priority (index 0
// highest) and a programmable vector base. One request at a time is offered
// to the CU over a four-phase handshake; the serviced source gets a
// one-cycle acknowledge once the CU accepts.
// Legal configurations: 1 <= N_SRC <= 31 and N_SRC <= 2**CODE_W - 1.
module intr_ctrl_n #(
  parameter int               N_SRC     = 8,
  parameter int               CODE_W    = 4,
  parameter int               VEC_SHIFT = 8,
  parameter logic [31:0]      BASE_RST  = 32'h0000_0000,
  parameter logic [N_SRC-1:0] MASK_RST  = '1,
  parameter logic [N_SRC-1:0] NMI_MASK  = N_SRC'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] i_src_req,
  output logic [N_SRC-1:0] o_src_ack,
  input  logic             i_msr_ee,
  input  logic             i_cfg_wr,
  input  logic [1:0]       i_cfg_addr,
  input  logic [0:31]      i_cfg_wd,
  output logic [0:31]      o_cfg_rd,
  intr_ctrl_n_if.master    cu
);

  localparam int               SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [N_SRC-1:0] ONE   = N_SRC'(1);

  localparam logic [1:0] A_MASK = 2'd0;
  localparam logic [1:0] A_BASE = 2'd1;
  localparam logic [1:0] A_PEND = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // waiting for an eligible source
    S_REQ  = 2'd1,  // cu_req held, waiting for cu_ack
    S_DONE = 2'd2   // ack given, waiting for cu_ack to drop
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [N_SRC-1:0]   r_pend;
  logic [N_SRC-1:0]   r_mask;
  logic [31:0]        r_base;

  logic               r_cu_req;
  logic [N_SRC-1:0]   r_src_ack;
  logic [CODE_W-1:0]  r_code;
  logic [31:0]        r_addr;
  logic [SEL_W-1:0]   r_sel;

  logic               w_cu_req_nxt;
  logic [N_SRC-1:0]   w_src_ack_nxt;
  logic [CODE_W-1:0]  w_code_nxt;
  logic [31:0]        w_addr_nxt;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic [N_SRC-1:0]   w_clr;

  logic [N_SRC-1:0]   w_elig;
  logic               w_any;
  logic [SEL_W-1:0]   w_sel;
  logic [N_SRC-1:0]   w_mask_wd;

  // Non-maskable sources bypass both the enable mask and MSR[EE]; only the
  // registered pending bits take part, never the raw request inputs.
  assign w_elig = r_pend & ((r_mask & {N_SRC{i_msr_ee}}) | NMI_MASK);

  // Fixed-priority encoder: lowest eligible index wins.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see the
    // updated value; every output gets a default first so no latch is built.
    w_any = |w_elig;
    w_sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_sel = SEL_W'(i);
    end
  end

  // Mask bit i lives at cfg_wd[31-i] (bit 31 is the LSB of the bus).
  always_comb begin
    w_mask_wd = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_mask_wd[i] = i_cfg_wd[31-i];
    end
  end

  // Handshake state register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // pre-edge values, independent of statement order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and next values of the registered handshake outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_cu_req_nxt  = r_cu_req;
    w_src_ack_nxt = '0;
    w_code_nxt    = r_code;
    w_addr_nxt    = r_addr;
    w_sel_nxt     = r_sel;
    w_clr         = '0;
    case (r_state)
      S_IDLE: begin
        // cu_ack seen here is ignored; only eligibility starts a request.
        if (w_any) begin
          w_sel_nxt    = w_sel;
          w_cu_req_nxt = 1'b1;
          w_code_nxt   = CODE_W'(w_sel) + CODE_W'(1);
          w_addr_nxt   = r_base + (32'(w_sel) << VEC_SHIFT);
          w_state_nxt  = S_REQ;
        end
      end
      S_REQ: begin
        // No preemption: code and address stay latched until cu_ack.
        if (cu.cu_ack) begin
          w_cu_req_nxt  = 1'b0;
          w_src_ack_nxt = ONE << r_sel;
          w_clr         = ONE << r_sel;
          w_state_nxt   = S_DONE;
        end
      end
      S_DONE: begin
        // Completing the four-phase cycle keeps cu_req low while cu_ack is high.
        if (!cu.cu_ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cu_req  <= 1'b0;
      r_src_ack <= '0;
      r_code    <= '0;
      r_addr    <= '0;
      r_sel     <= '0;
    end else begin
      r_cu_req  <= w_cu_req_nxt;
      r_src_ack <= w_src_ack_nxt;
      r_code    <= w_code_nxt;
      r_addr    <= w_addr_nxt;
      r_sel     <= w_sel_nxt;
    end
  end

  // Sticky pending latches (acknowledge clear wins) and config registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_mask <= MASK_RST;
      r_base <= BASE_RST;
    end else begin
      r_pend <= (r_pend | i_src_req) & ~w_clr;
      if (i_cfg_wr && (i_cfg_addr == A_MASK)) r_mask <= w_mask_wd;
      if (i_cfg_wr && (i_cfg_addr == A_BASE)) r_base <= i_cfg_wd;
    end
  end

  // Combinational configuration readback; unused bits read as zero.
  always_comb begin
    o_cfg_rd = '0;
    case (i_cfg_addr)
      A_MASK:  o_cfg_rd = 32'(r_mask);
      A_BASE:  o_cfg_rd = r_base;
      A_PEND:  o_cfg_rd = 32'(r_pend);
      default: o_cfg_rd = '0;
    endcase
  end

  assign o_src_ack          = r_src_ack;
  assign cu.cu_req          = r_cu_req;
  assign cu.excep_code      = r_code;
  assign cu.intr_entry_addr = r_addr;

endmodule

// File: tb/tb_intr_ctrl_n.sv
// Bench for intr_ctrl_n: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle against a transaction-level
// model (which source is in service, whether it has been acknowledged).
module tb_intr_ctrl_n;

  localparam int N      = 8;
  localparam int CW     = 4;
  localparam int VS     = 8;
  localparam bit [N-1:0] NMI = 8'h01;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  src_req = '0;
  logic [N-1:0]  src_ack;
  logic          msr_ee = 1'b1;
  logic          cfg_wr = 1'b0;
  logic [1:0]    cfg_addr = 2'd0;
  logic [0:31]   cfg_wd = '0;
  logic [0:31]   cfg_rd;

  int n_tests = 0;
  int n_fail  = 0;

  intr_ctrl_n_if #(.CODE_W(CW)) cu_if ();

  intr_ctrl_n #(
    .N_SRC(N), .CODE_W(CW), .VEC_SHIFT(VS),
    .BASE_RST(32'h0), .MASK_RST(8'hFF), .NMI_MASK(NMI)
  ) dut (
    .clk(clk), .rst(rst),
    .i_src_req(src_req), .o_src_ack(src_ack),
    .i_msr_ee(msr_ee),
    .i_cfg_wr(cfg_wr), .i_cfg_addr(cfg_addr), .i_cfg_wd(cfg_wd),
    .o_cfg_rd(cfg_rd),
    .cu(cu_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int       m_srv;      // source in service, -1 when none
  bit       m_acked;    // CU has accepted, waiting for cu_ack to fall
  bit       m_req;
  bit [3:0] m_code;
  bit [31:0] m_addr, m_base;
  bit [N-1:0] m_pend, m_mask, m_ack, m_old;
  int       m_pick, m_clr;
  bit [31:0] m_wd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_srv = -1; m_acked = 0; m_req = 0; m_code = 0; m_addr = 0;
      m_base = 0; m_pend = 0; m_mask = '1; m_ack = 0;
    end else begin
      m_old = m_pend;
      m_clr = -1;
      m_ack = 0;
      if (m_srv < 0) begin
        m_pick = -1;
        for (int i = N - 1; i >= 0; i--)
          if (m_old[i] && ((m_mask[i] && msr_ee) || NMI[i])) m_pick = i;
        if (m_pick >= 0) begin
          m_srv  = m_pick;
          m_req  = 1;
          m_code = 4'(m_pick + 1);
          m_addr = m_base + 32'(m_pick * (1 << VS));
        end
      end else if (!m_acked) begin
        if (cu_if.cu_ack) begin
          m_req = 0; m_ack[m_srv] = 1; m_clr = m_srv; m_acked = 1;
        end
      end else if (!cu_if.cu_ack) begin
        m_srv = -1; m_acked = 0;
      end
      for (int i = 0; i < N; i++)
        m_pend[i] = (i == m_clr) ? 1'b0 : (m_old[i] | src_req[i]);
      m_wd = cfg_wd;
      if (cfg_wr && cfg_addr == 2'd0) m_mask = m_wd[N-1:0];
      if (cfg_wr && cfg_addr == 2'd1) m_base = m_wd;
    end
  end

  function automatic logic [31:0] m_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {24'h0, m_mask};
      2'd1:    return m_base;
      2'd2:    return {24'h0, m_pend};
      default: return 32'h0;
    endcase
  endfunction

  // Per-cycle compare, just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      check("cmp_cu_req", {31'h0, cu_if.cu_req}, {31'h0, m_req});
      check("cmp_code",   {28'h0, cu_if.excep_code}, {28'h0, m_code});
      check("cmp_addr",   cu_if.intr_entry_addr, m_addr);
      check("cmp_src_ack", {24'h0, src_ack}, {24'h0, m_ack});
      check("cmp_cfg_rd", cfg_rd, m_rd(cfg_addr));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wd = d;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] r);
    src_req = r;
    @(negedge clk);
    src_req = '0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (cu_if.cu_req === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) check("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic handshake(input int code, input logic [31:0] addr);
    bit ok;
    wait_req(ok);
    if (ok) begin
      check("hs_code", {28'h0, cu_if.excep_code}, 32'(code));
      check("hs_addr", cu_if.intr_entry_addr, addr);
      cu_if.cu_ack = 1'b1;
      @(negedge clk);
      check("hs_ack_pulse", {24'h0, src_ack}, 32'(1 << (code - 1)));
      check("hs_req_drop", {31'h0, cu_if.cu_req}, 32'd0);
      cu_if.cu_ack = 1'b0;
      @(negedge clk);
      check("hs_ack_end", {24'h0, src_ack}, 32'd0);
    end
  endtask

  initial begin
    bit ok;
    cu_if.cu_ack = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cfg_addr = 2'd0;
    @(negedge clk);
    check("rst_cu_req", {31'h0, cu_if.cu_req}, 32'd0);
    check("rst_code", {28'h0, cu_if.excep_code}, 32'd0);
    check("rst_mask", cfg_rd, 32'h0000_00FF);

    // Single source with a high vector base.
    msr_ee = 1'b1;
    cfg_write(2'd1, 32'hFFF0_0000);
    pulse(8'h08);
    check("t1_not_yet", {31'h0, cu_if.cu_req}, 32'd0);
    @(negedge clk);
    check("t1_req", {31'h0, cu_if.cu_req}, 32'd1);
    handshake(4, 32'hFFF0_0300);
    cfg_addr = 2'd2;
    @(negedge clk);
    check("t1_pend", cfg_rd, 32'h0);

    // Two simultaneous sources, served by priority.
    cfg_write(2'd1, 32'h0);
    pulse(8'h24);
    handshake(3, 32'h200);
    handshake(6, 32'h500);

    // EE blocks maskable sources but not the NMI source.
    msr_ee = 1'b0;
    cfg_addr = 2'd2;
    pulse(8'h11);
    handshake(1, 32'h000);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t3_no_req", {31'h0, cu_if.cu_req}, 32'd0);
    end
    check("t3_pend", cfg_rd, 32'h0000_0010);
    msr_ee = 1'b1;
    handshake(5, 32'h400);

    // Masked source stays pending until unmasked.
    cfg_write(2'd0, 32'h0000_00BF);
    pulse(8'h40);
    cfg_addr = 2'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_no_req", {31'h0, cu_if.cu_req}, 32'd0);
    end
    check("t4_pend", cfg_rd, 32'h0000_0040);
    cfg_write(2'd0, 32'h0000_00FF);
    handshake(7, 32'h600);

    // No preemption, and cu_req stays low while cu_ack is held.
    pulse(8'h20);
    wait_req(ok);
    check("t5_code6", {28'h0, cu_if.excep_code}, 32'd6);
    pulse(8'h02);
    @(negedge clk);
    check("t5_hold_code", {28'h0, cu_if.excep_code}, 32'd6);
    check("t5_hold_req", {31'h0, cu_if.cu_req}, 32'd1);
    cu_if.cu_ack = 1'b1;
    @(negedge clk);
    check("t5_ack", {24'h0, src_ack}, 32'h20);
    @(negedge clk);
    check("t5_done_req", {31'h0, cu_if.cu_req}, 32'd0);
    check("t5_done_ack", {24'h0, src_ack}, 32'd0);
    @(negedge clk);
    check("t5_done_req2", {31'h0, cu_if.cu_req}, 32'd0);
    cu_if.cu_ack = 1'b0;
    @(negedge clk);
    check("t5_idle_req", {31'h0, cu_if.cu_req}, 32'd0);
    handshake(2, 32'h100);

    // Asynchronous reset in the middle of a request.
    cfg_write(2'd1, 32'h1234_0000);
    cfg_write(2'd0, 32'h0000_007F);
    pulse(8'h08);
    wait_req(ok);
    check("t6_addr", cu_if.intr_entry_addr, 32'h1234_0300);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_req", {31'h0, cu_if.cu_req}, 32'd0);
    check("t6_rst_code", {28'h0, cu_if.excep_code}, 32'd0);
    check("t6_rst_ack", {24'h0, src_ack}, 32'd0);
    check("t6_rst_addr", cu_if.intr_entry_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cfg_addr = 2'd0;
    @(negedge clk);
    check("t6_mask", cfg_rd, 32'h0000_00FF);
    cfg_addr = 2'd1;
    @(negedge clk);
    check("t6_base", cfg_rd, 32'h0);
    cfg_addr = 2'd2;
    @(negedge clk);
    check("t6_pend", cfg_rd, 32'h0);
    check("t6_lost", {31'h0, cu_if.cu_req}, 32'd0);

    // Randomized traffic, checked by the per-cycle compare.
    for (int c = 0; c < 3000; c++) begin
      src_req = ($urandom_range(0, 3) == 0) ? (N'($urandom) & N'($urandom)) : '0;
      cu_if.cu_ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) msr_ee = ~msr_ee;
      cfg_addr = 2'($urandom_range(0, 3));
      cfg_wr = ($urandom_range(0, 15) == 0);
      cfg_wd = (cfg_addr == 2'd0) ? ($urandom | $urandom) : $urandom;
      @(negedge clk);
    end
    src_req = '0;
    cfg_wr = 1'b0;
    cu_if.cu_ack = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/intr_ctrl_n.md
Name: intr_ctrl_n

Overview:
- Parametrised successor to the fixed eight-source interrupt system. It generalises to N_SRC request sources with sticky pending latches, a programmable per-source enable mask, a per-source non-maskable attribute and a programmable vector base.
- It arbitrates pending sources by fixed priority (index 0 highest). It drives one exception request, with code and entry address, to the control unit (CU) over a four-phase req/ack handshake. On completion it returns a one-cycle ack to the serviced source.
- It sits between the exception/device sources and the CU. MSR[EE] gates maskable sources.

Parameters:
- N_SRC, 8, number of sources; legal range 1..31.
- CODE_W, 4, exception code width; must satisfy N_SRC <= 2^CODE_W - 1.
- VEC_SHIFT, 8, entry address stride is 2^VEC_SHIFT bytes.
- BASE_RST, 32'h0000_0000, reset value of the vector base register.
- MASK_RST, all ones (N_SRC bits), reset value of the enable mask.
- NMI_MASK, 8'h01, bit i = 1 makes source i ignore both the enable mask and MSR[EE].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- src_req  in  N_SRC  per-source request; a pulse or a level.
- src_ack  out  N_SRC  per-source one-cycle service acknowledge.
- msr_ee  in  1  MSR external-enable bit.
- cfg_wr  in  1  configuration write strobe.
- cfg_addr  in  2  0 = mask, 1 = base, 2 = pending (read-only), 3 = reserved.
- cfg_wd  in  [0:31]  configuration write data.
- cfg_rd  out  [0:31]  configuration read data; combinational.
- cu_req  out  1  interrupt request to the CU.
- cu_ack  in  1  CU acknowledge.
- excep_code  out  CODE_W  code of the serviced source, sel+1; 0 = none.
- intr_entry_addr  out  [0:31]  handler entry address.

Behaviour:
- Reset (async, immediate): state = IDLE; cu_req = 0; src_ack = 0; excep_code = 0; intr_entry_addr = 0; pend = 0; mask = MASK_RST; base = BASE_RST.
- Pending capture: every edge, pend[i] <= pend[i] | src_req[i].
  - Exception: in the cycle src_ack[i] = 1, pend[i] clears regardless of src_req[i] (clear wins).
  - A src_req[i] still high on the following edge re-pends. Sources must drop req within one cycle of ack.
- Eligibility: elig[i] = pend[i] & ((mask[i] & msr_ee) | NMI_MASK[i]). Only registered pend is used, with no bypass from src_req.
- Selection: sel = lowest index with elig = 1.
- Configuration registers:
  - Mask bit i maps to cfg_wd[31-i]. Writes to the unused upper bits are ignored; those bits read 0.
  - base is 32 bits and is fully writable.
  - Writes to cfg_addr 2 and 3 have no effect.
  - cfg_rd at cfg_addr 2 returns pend, with bit i at position 31-i. cfg_rd at cfg_addr 3 returns 0.
- Configuration writes take effect at the edge and may occur in any state. In REQ/DONE they do not alter the latched code or address, and do not withdraw cu_req.
- FSM, all outputs registered:
  - IDLE: if any elig, latch sel. Drive cu_req = 1, excep_code = sel+1, intr_entry_addr = base + (sel << VEC_SHIFT) (mod 2^32). Go to REQ.
  - REQ: hold cu_req, excep_code and intr_entry_addr stable. No preemption: a newly eligible higher-priority source waits. On cu_ack = 1: cu_req <= 0, src_ack[sel] <= 1 for one cycle, pend[sel] cleared. Go to DONE.
  - DONE: src_ack returns to 0. excep_code and intr_entry_addr hold their last values. When cu_ack = 0, go to IDLE. cu_req must not re-assert while cu_ack is high.
- Latency: src_req sampled at edge k gives cu_req = 1 after edge k+1 when the FSM is idle. Back-to-back service needs a minimum of 3 edges between cu_req rising edges.
- A cu_ack seen in IDLE is ignored.
- Masked or EE-blocked sources stay pending indefinitely and are served once enabled.
- Reset mid-handshake: all outputs drop asynchronously. A pending or selected request is lost.

Test Plan:
- Reset, write base = 32'hFFF0_0000, msr_ee = 1, pulse src_req[3] for 1 cycle -> cu_req = 1 two edges later with excep_code = 4 and intr_entry_addr = 32'hFFF0_0300. cu_ack = 1 for 1 cycle -> src_ack = 8'h08 for exactly 1 cycle; pending readback = 0.
- src_req[2] and src_req[5] in the same cycle -> first excep_code = 3 at entry 0x200 after a full handshake, then excep_code = 6 at entry 0x500. Each src_ack is a one-cycle pulse.
- msr_ee = 0, pulse src_req[4] and src_req[0] -> only code 1 is issued. pend = 8'h10 remains and no further cu_req occurs. Set msr_ee = 1 -> code 5 is issued.
- Write mask = 32'h0000_00BF (bit 6 cleared), pulse src_req[6] -> cfg_rd at cfg_addr 2 = 32'h0000_0040 and no cu_req. Write mask = 32'h0000_00FF -> code 7 is issued.
- In REQ with code 6, pulse src_req[1] -> code stays 6. Hold cu_ack high for 3 cycles -> cu_req stays 0 until cu_ack falls, then code 2 is issued.
- Assert rst mid-REQ -> cu_req, src_ack and excep_code are 0 before the next clock edge. After release: mask = 8'hFF, base = 0, pend = 0.
